mem_io_responder: RTL and testbench

- Bus responder for the simple RISC CPU's memory port, on the opposite end from the CPU's ldr/str initiator logic.
- Decodes CPU memory commands and serves a 256x16 data/instruction RAM, a memory-mapped LED register and a memory-mapped switch input.
- Adds a wait-state/acknowledge handshake so the CPU's memory FSM can be exercised against slow memory.
- Sits beside the CPU inside the top-level task wrapper.

---
 rtl/mem_pkg.sv | 39 +++
 rtl/sp_ram_256x16.sv | 37 +++
 rtl/mem_io_responder.sv | 165 ++++++++++++++++
 tb/tb_mem_io_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the CPU memory-port responder: bus command
// encodings, the memory-mapped I/O addresses, RAM geometry and the
// responder FSM state codes.
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 9;
    localparam int RAM_AW    = 8;
    localparam int RAM_DEPTH = 256;

    // Bus command encodings driven by the CPU's ldr/str logic.
    // Code 2'b11 is not a legal command but can appear on the wires.
    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10
    } mem_cmd_e;

    localparam logic [1:0] CMD_ILLEGAL = 2'b11;

    // Memory-mapped peripherals sit above the 256-word RAM window.
    localparam logic [ADDR_W-1:0] ADDR_LED = 9'h100;
    localparam logic [ADDR_W-1:0] ADDR_SW  = 9'h140;

    // Responder FSM state codes, kept as plain constants so older
    // code that compares raw 2-bit values keeps working.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // The RAM occupies every address with the top address bit clear.
    function automatic logic is_ram_addr(input logic [ADDR_W-1:0] addr);
        return !addr[ADDR_W-1];
    endfunction

endpackage

// File: rtl/sp_ram_256x16.sv
// ---------------------------------------------------------------------------
// sp_ram_256x16
// Single-port 256x16 RAM holding both program and data words.
// Writes commit on the rising clock edge; reads are combinational so the
// responder can present the word in the same cycle it acknowledges.
//
// Ports:
//   clk    system clock
//   we     write enable, sampled on the rising edge
//   addr   word address (8 bits)
//   wdata  write data
//   rdata  combinational read data for addr
// ---------------------------------------------------------------------------
module sp_ram_256x16
    import mem_pkg::*;
#(
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              we,
    input  logic [RAM_AW-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [RAM_DEPTH];

    // Write port: one word per clock when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_io_responder.sv
// ---------------------------------------------------------------------------
// mem_io_responder
// Target side of the CPU memory port. Accepts one command at a time,
// optionally stretches it by WAIT_STATES cycles, then completes it with a
// single-cycle mem_ack. Serves a 256x16 RAM, an LED register at 0x100 and
// the board switches at 0x140; anything else completes with bus_err.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   mem_cmd     00 none, 01 read, 10 write, 11 illegal
//   mem_addr    9-bit word address
//   write_data  store data
//   read_data   load data, valid in the ack cycle, held otherwise
//   mem_ack     one-cycle completion pulse
//   bus_err     one-cycle error pulse, only together with mem_ack
//   sw          board switches
//   ledr        LED register
// ---------------------------------------------------------------------------
module mem_io_responder
    import mem_pkg::*;
#(
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_ack,
    output logic              bus_err,
    input  logic [7:0]        sw,
    output logic [7:0]        ledr
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [1:0]        state;
    logic [1:0]        lat_cmd;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [3:0]        wait_cnt;
    logic [DATA_W-1:0] read_hold;
    logic [DATA_W-1:0] ram_rdata;

    logic              resp_valid;
    logic              resp_load;
    logic              resp_err;
    logic [DATA_W-1:0] resp_rdata;
    logic              ram_we;
    logic              led_we;

    // A reset arriving in the response cycle cancels the transaction, so
    // the ack and any side effects are suppressed in that same cycle.
    assign resp_valid = (state == ST_RESP) && !rst;

    sp_ram_256x16 #(
        .INIT_FILE(INIT_FILE)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (lat_addr[RAM_AW-1:0]),
        .wdata(lat_wdata),
        .rdata(ram_rdata)
    );

    // Address/command decode of the latched request. Reads and illegal
    // commands both update read_data (illegal ones to zero); writes leave
    // it alone. Unmapped targets and switch writes flag an error.
    always_comb begin
        resp_load  = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        ram_we     = 1'b0;
        led_we     = 1'b0;
        if (lat_cmd == MEM_READ) begin
            resp_load = 1'b1;
            if (is_ram_addr(lat_addr)) begin
                resp_rdata = ram_rdata;
            end else if (lat_addr == ADDR_LED) begin
                resp_rdata = {8'h00, ledr};
            end else if (lat_addr == ADDR_SW) begin
                resp_rdata = {8'h00, sw};
            end else begin
                resp_err = 1'b1;
            end
        end else if (lat_cmd == MEM_WRITE) begin
            if (is_ram_addr(lat_addr)) begin
                ram_we = resp_valid;
            end else if (lat_addr == ADDR_LED) begin
                led_we = resp_valid;
            end else begin
                resp_err = 1'b1;
            end
        end else if (lat_cmd == CMD_ILLEGAL) begin
            resp_load = 1'b1;
            resp_err  = 1'b1;
        end
    end

    // Request FSM. The request is captured once in IDLE and the live bus
    // inputs are ignored until the ack has gone out. The wait counter
    // runs from WAIT_STATES-1 down to zero, one cycle per count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            lat_cmd   <= MEM_NONE;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_cmd != MEM_NONE) begin
                        lat_cmd   <= mem_cmd;
                        lat_addr  <= mem_addr;
                        lat_wdata <= write_data;
                        if (WAIT_STATES > 0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered side of the response: the held read value and the LED
    // register. RAM contents are deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_hold <= '0;
            ledr      <= 8'h00;
        end else begin
            if (resp_valid && resp_load) begin
                read_hold <= resp_rdata;
            end
            if (led_we) begin
                ledr <= lat_wdata[7:0];
            end
        end
    end

    assign mem_ack   = resp_valid;
    assign bus_err   = resp_valid && resp_err;
    assign read_data = (resp_valid && resp_load) ? resp_rdata : read_hold;

endmodule

// File: tb/tb_mem_io_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_io_responder
// Directed bench for mem_io_responder. Two instances run side by side:
// index 0 with no wait states, index 1 with three. A table of single
// transactions covers the address map, then hand-written sequences cover
// input changes during WAIT, reset mid-transaction, reset versus request
// and back-to-back requests.
// ---------------------------------------------------------------------------
module tb_mem_io_responder;

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_RD   = 2'b01;
    localparam logic [1:0] C_WR   = 2'b10;
    localparam logic [1:0] C_BAD  = 2'b11;

    typedef struct {
        int          d;
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] wdata;
        logic [7:0]  sw;
        logic [15:0] exp_rd;
        logic        exp_err;
        logic [7:0]  exp_led;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic [1:0]  cmd   [2];
    logic [8:0]  addr  [2];
    logic [15:0] wdata [2];
    logic [7:0]  sw;
    logic [15:0] rd    [2];
    logic        ack   [2];
    logic        err   [2];
    logic [7:0]  led   [2];

    int vectors     = 0;
    int checks      = 0;
    int miscompares = 0;

    vec_t vecs [15];

    // Free-running 10 ns clock shared by both instances.
    always #5 clk = ~clk;

    mem_io_responder #(
        .WAIT_STATES(0),
        .INIT_FILE  ("")
    ) dut0 (
        .clk       (clk),
        .rst       (rst[0]),
        .mem_cmd   (cmd[0]),
        .mem_addr  (addr[0]),
        .write_data(wdata[0]),
        .read_data (rd[0]),
        .mem_ack   (ack[0]),
        .bus_err   (err[0]),
        .sw        (sw),
        .ledr      (led[0])
    );

    mem_io_responder #(
        .WAIT_STATES(3),
        .INIT_FILE  ("")
    ) dut3 (
        .clk       (clk),
        .rst       (rst[1]),
        .mem_cmd   (cmd[1]),
        .mem_addr  (addr[1]),
        .write_data(wdata[1]),
        .read_data (rd[1]),
        .mem_ack   (ack[1]),
        .bus_err   (err[1]),
        .sw        (sw),
        .ledr      (led[1])
    );

    // One comparison: count it, and report it if the values differ.
    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one command on instance d and wait (bounded) for its ack,
    // sampling on falling edges. With scramble set, the address and data
    // are disturbed every cycle after acceptance. Returns with the command
    // removed, at the falling edge inside the ack cycle; lat is -1 on timeout.
    task automatic applyStimulus(input int d, input logic [1:0] c, input logic [8:0] a,
                                 input logic [15:0] w, input bit scramble,
                                 output int lat, output logic [15:0] r, output logic e);
        @(negedge clk);
        cmd[d]   = c;
        addr[d]  = a;
        wdata[d] = w;
        lat = -1;
        r   = 'x;
        e   = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ack[d]) begin
                lat = k;
                r   = rd[d];
                e   = err[d];
                break;
            end
            if (scramble) begin
                addr[d]  = ~addr[d];
                wdata[d] = wdata[d] ^ 16'h5A5A;
            end
        end
        cmd[d] = C_NONE;
    endtask

    // Hard stop in case something in the bench itself stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        int          lat;
        logic [15:0] r;
        logic        e;
        int          acks;
        int          pos1;
        int          pos2;
        logic [15:0] rd_at2;

        vecs[0]  = '{0, C_WR,  9'h0FF, 16'd69,   8'h00, 16'h0000, 1'b0, 8'h00, "wr_ram_0ff"};
        vecs[1]  = '{0, C_RD,  9'h0FF, 16'h0000, 8'h00, 16'd69,   1'b0, 8'h00, "rd_ram_0ff"};
        vecs[2]  = '{0, C_WR,  9'h100, 16'h01A5, 8'h00, 16'd69,   1'b0, 8'hA5, "wr_led"};
        vecs[3]  = '{0, C_RD,  9'h100, 16'h0000, 8'h00, 16'h00A5, 1'b0, 8'hA5, "rd_led"};
        vecs[4]  = '{0, C_RD,  9'h140, 16'h0000, 8'h5C, 16'h005C, 1'b0, 8'hA5, "rd_sw"};
        vecs[5]  = '{0, C_WR,  9'h140, 16'h00FF, 8'h5C, 16'h005C, 1'b1, 8'hA5, "wr_sw_err"};
        vecs[6]  = '{0, C_RD,  9'h1C0, 16'h0000, 8'h5C, 16'h0000, 1'b1, 8'hA5, "rd_unmapped"};
        vecs[7]  = '{0, C_BAD, 9'h0FF, 16'h1234, 8'h5C, 16'h0000, 1'b1, 8'hA5, "illegal_cmd"};
        vecs[8]  = '{0, C_RD,  9'h0FF, 16'h0000, 8'h5C, 16'd69,   1'b0, 8'hA5, "rd_after_err"};
        vecs[9]  = '{0, C_WR,  9'h1C0, 16'hBEEF, 8'h5C, 16'd69,   1'b1, 8'hA5, "wr_unmapped"};
        vecs[10] = '{0, C_RD,  9'h100, 16'h0000, 8'h00, 16'h00A5, 1'b0, 8'hA5, "rd_led_again"};
        vecs[11] = '{1, C_WR,  9'h0FE, 16'd6969, 8'h00, 16'h0000, 1'b0, 8'h00, "ws3_wr_0fe"};
        vecs[12] = '{1, C_WR,  9'h010, 16'd20,   8'h00, 16'h0000, 1'b0, 8'h00, "ws3_wr_010"};
        vecs[13] = '{1, C_WR,  9'h100, 16'h0077, 8'h00, 16'h0000, 1'b0, 8'h77, "ws3_wr_led"};
        vecs[14] = '{1, C_RD,  9'h100, 16'h0000, 8'h00, 16'h0077, 1'b0, 8'h77, "ws3_rd_led"};

        sw = 8'h00;
        for (int i = 0; i < 2; i++) begin
            rst[i]   = 1'b1;
            cmd[i]   = C_NONE;
            addr[i]  = '0;
            wdata[i] = '0;
        end

        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("reset_rd%0d", i),  rd[i],           16'h0000);
            checkOutput($sformatf("reset_ack%0d", i), {15'd0, ack[i]}, 16'h0000);
            checkOutput($sformatf("reset_err%0d", i), {15'd0, err[i]}, 16'h0000);
            checkOutput($sformatf("reset_led%0d", i), {8'h00, led[i]}, 16'h0000);
            rst[i] = 1'b0;
        end
        vectors++;

        $display("[TB] applying table vectors");
        for (int i = 0; i < 15; i++) begin
            sw = vecs[i].sw;
            applyStimulus(vecs[i].d, vecs[i].cmd, vecs[i].addr, vecs[i].wdata, 1'b0, lat, r, e);
            vectors++;
            checkOutput({vecs[i].name, "_latency"}, 16'(lat), 16'(1 + 3 * vecs[i].d));
            checkOutput({vecs[i].name, "_rdata"},   r,            vecs[i].exp_rd);
            checkOutput({vecs[i].name, "_err"},     {15'd0, e},   {15'd0, vecs[i].exp_err});
            @(negedge clk);
            checkOutput({vecs[i].name, "_ack_pulse"}, {15'd0, ack[vecs[i].d]}, 16'h0000);
            checkOutput({vecs[i].name, "_err_clear"}, {15'd0, err[vecs[i].d]}, 16'h0000);
            checkOutput({vecs[i].name, "_ledr"}, {8'h00, led[vecs[i].d]}, {8'h00, vecs[i].exp_led});
        end

        $display("[TB] wait-state read with inputs disturbed during WAIT");
        applyStimulus(1, C_RD, 9'h0FE, 16'h0000, 1'b1, lat, r, e);
        vectors++;
        checkOutput("scramble_latency", 16'(lat), 16'd4);
        checkOutput("scramble_rdata",   r,        16'd6969);
        checkOutput("scramble_err",     {15'd0, e}, 16'h0000);
        @(negedge clk);
        checkOutput("scramble_ack_pulse", {15'd0, ack[1]}, 16'h0000);

        $display("[TB] reset in the second WAIT cycle");
        @(negedge clk);
        cmd[1]   = C_WR;
        addr[1]  = 9'h010;
        wdata[1] = 16'd50;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst[1] = 1'b1;
        cmd[1] = C_NONE;
        @(negedge clk);
        rst[1] = 1'b0;
        checkOutput("midrst_led", {8'h00, led[1]}, 16'h0000);
        checkOutput("midrst_rd",  rd[1],           16'h0000);
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ack[1]) acks++;
        end
        checkOutput("midrst_no_ack", 16'(acks), 16'd0);
        applyStimulus(1, C_RD, 9'h010, 16'h0000, 1'b0, lat, r, e);
        vectors++;
        checkOutput("midrst_read_latency", 16'(lat), 16'd4);
        checkOutput("midrst_read_old",     r,        16'd20);
        checkOutput("midrst_read_led",     {8'h00, led[1]}, 16'h0000);

        $display("[TB] reset and request in the same cycle");
        @(negedge clk);
        rst[0]   = 1'b1;
        cmd[0]   = C_WR;
        addr[0]  = 9'h100;
        wdata[0] = 16'h00FF;
        @(negedge clk);
        rst[0] = 1'b0;
        cmd[0] = C_NONE;
        acks = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (ack[0]) acks++;
        end
        vectors++;
        checkOutput("rstwin_no_ack", 16'(acks), 16'd0);
        checkOutput("rstwin_led",    {8'h00, led[0]}, 16'h0000);

        $display("[TB] back-to-back reads with the command held");
        @(negedge clk);
        cmd[0]  = C_RD;
        addr[0] = 9'h0FF;
        acks    = 0;
        pos1    = -1;
        pos2    = -1;
        rd_at2  = 'x;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (ack[0]) begin
                acks++;
                if (acks == 1) pos1 = k;
                if (acks == 2) begin
                    pos2   = k;
                    rd_at2 = rd[0];
                    cmd[0] = C_NONE;
                end
            end
        end
        cmd[0] = C_NONE;
        vectors++;
        checkOutput("b2b_ack_count",  16'(acks), 16'd2);
        checkOutput("b2b_first_ack",  16'(pos1), 16'd1);
        checkOutput("b2b_second_ack", 16'(pos2), 16'd3);
        checkOutput("b2b_rdata",      rd_at2,    16'd69);

        $display("[TB] %0d comparisons made", checks);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
